pico_sseg_scan: RTL
===================

Name: pico_sseg_scan

Overview:
- PicoRV32 memory-mapped seven-segment display controller; parametrised successor to the fixed 4-digit LED mux peripheral.
- Holds up to 8 digit patterns and time-multiplexes them onto one shared segment bus with per-digit anode drive.
- Adds a registered bus handshake, hex-decode mode, per-digit enable mask, 16-level PWM brightness and a read-only status register.
- Sits on the PicoRV32 native bus behind the SoC address decoder, which supplies busin_valid already qualified for this block.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 1..8.
- PHASE_DIV, 3125, clock cycles per PWM phase. One digit slot is 16 phases (default 50000 cycles).

Ports:
- clk  input  1  system clock; the only clock.
- resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- busin_valid  input  1  bus request, already address-qualified.
- busin_addr  input  32  byte address; only [3:2] decoded.
- busin_wdata  input  32  write data.
- busin_wstrb  input  4  byte write strobes; 0 = read.
- busout_ready  output  1  one-cycle acknowledge.
- busout_rdata  output  32  read data, valid while busout_ready=1, else 0.
- busout_sseg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
- busout_led  output  NUM_DIGITS  digit anode enables, active-low; bit i = digit i.

Behaviour:
- Reset (resetn=0 at a clk edge), taking effect mid-scan or mid-transaction:
  - busout_ready=0, busout_rdata=0, busout_sseg=8'hFF, busout_led all ones.
  - DATA_LO=0, DATA_HI=0; CTRL: hex=0, enable mask=all ones, bright=15.
  - Phase counter, digit index and frame bit cleared.
  - Any pending bus request is dropped.
- Register map (busin_addr[3:2]):
  - 0 DATA_LO: byte i = digit i pattern, digits 0-3.
  - 1 DATA_HI: byte i = digit 4+i. Reads 0 and ignores writes when NUM_DIGITS<=4. Bytes for digits >= NUM_DIGITS read 0.
  - 2 CTRL: bit0 hex mode; [15:8] enable mask, bits >= NUM_DIGITS read 0; [19:16] bright; all other bits read 0.
  - 3 STATUS, read-only: [2:0] current digit index; [8] frame bit, toggles each time index wraps to 0. Writes ignored.
- Bus handshake:
  - Request accepted when busin_valid=1 and busout_ready=0. busout_ready goes high on the next clk edge for exactly one cycle.
  - Write: only bytes with busin_wstrb set update, at the ready edge. The new value is visible to the scan logic from the cycle after ready.
  - Read: busout_rdata carries the register value as sampled at the accept cycle.
  - If busin_valid stays high, ready pulses every other cycle.
- Scan:
  - The phase counter counts PHASE_DIV cycles per phase. Phase 0..15 increments, and wraps 15->0 with the digit index advancing.
  - Index counts 0..NUM_DIGITS-1, then wraps to 0.
  - Digit i is lit when index=i, enable mask bit i=1, and phase <= bright. Lit means busout_led[i]=0 and sseg=~pattern.
  - Otherwise all anodes are high and sseg=8'hFF.
  - bright=15 gives a 100% duty cycle; bright=0 gives 1/16.
- Pattern:
  - Raw mode: the data byte is an active-high segment pattern.
  - Hex mode: low nibble decoded with the standard table (0=0x3F, 1=0x06, 5=0x6D, 8=0x7F, A=0x77, F=0x71). Bit7 of the byte is the decimal point. Bits [6:4] are ignored.
- Outputs are registered: sseg and led change one cycle after the phase or index change that causes them. No glitches between digits; all anodes are high for that transition cycle.
- A write to CTRL or DATA never resets the phase counter or digit index.

Optional Feature:
- Macro SSEG_BLINK_EN.
- When defined:
  - CTRL[31:24] is a per-digit blink mask.
  - A blink counter toggles a blink-state bit every 64 full frames.
  - While blink-state=1, masked digits are blanked (anode high, sseg 8'hFF).
  - The counter is cleared by reset.
- When undefined: CTRL[31:24] reads 0, writes are ignored, and no blink logic is present.

Test Plan:
- Reset: hold resetn=0 for 3 cycles mid-scan. Expect sseg=8'hFF and led=4'hF on the next edge, and CTRL reads 0x000F_0F00 (NUM_DIGITS=4).
- Write DATA_LO=0x3F06_5B4F, wstrb=4'hF. Expect ready one cycle after valid. Within the digit-0 slot, led=4'hE and sseg=8'hB0.
- Hex mode: write CTRL=0x000F_0F01 and DATA_LO byte0=0x85 with wstrb=4'h1 only. Expect digit 0 sseg=~0xED=8'h12 and bytes 1-3 unchanged.
- Brightness: bright=3, PHASE_DIV=4. Expect the digit lit for 16 cycles, then dark for 48 cycles, within each 64-cycle slot.
- Enable mask: mask=4'b0101. Expect digits 1 and 3 never driven low on led. STATUS index still walks 0,1,2,3,0, and the frame bit toggles.
- Handshake: hold busin_valid high for 4 cycles reading STATUS. Expect ready=1,0,1,0, and rdata=0 whenever ready=0.

Source files
------------

// File: rtl/pico_sseg_scan.sv
// Memory-mapped seven-segment scanner for the PicoRV32 native bus: up to 8 digits, hex decode, PWM brightness.
// Optional per-digit blink is compiled in when SSEG_BLINK_EN is defined.
module pico_sseg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PHASE_DIV  = 3125
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  busin_valid,
  input  logic [31:0]           busin_addr,
  input  logic [31:0]           busin_wdata,
  input  logic [3:0]            busin_wstrb,
  output logic                  busout_ready,
  output logic [31:0]           busout_rdata,
  output logic [7:0]            busout_sseg,
  output logic [NUM_DIGITS-1:0] busout_led
);

  localparam int unsigned CNT_W = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  logic                       ready_q, ready_d;
  logic [31:0]                rdata_q, rdata_d;
  logic [7:0]                 sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0]      led_q, led_d;
  logic [NUM_DIGITS-1:0][7:0] pat_q, pat_d;
  logic                       hex_q, hex_d;
  logic [NUM_DIGITS-1:0]      en_q, en_d;
  logic [3:0]                 bright_q, bright_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [3:0]                 phase_q, phase_d;
  logic [2:0]                 idx_q, idx_d;
  logic                       frame_q, frame_d;
`ifdef SSEG_BLINK_EN
  logic [NUM_DIGITS-1:0]      blink_mask_q, blink_mask_d;
  logic [5:0]                 blink_cnt_q, blink_cnt_d;
  logic                       blink_q, blink_d;
`endif

  logic        accept, is_wr, is_rd;
  logic [1:0]  sel;
  logic        cnt_last, slot_end, frame_wrap;
  logic [63:0] data_all;
  logic [31:0] ctrl_rd, status_rd, rd_val;
  logic [NUM_DIGITS-1:0] vis;
  logic        unused_ok;

  assign unused_ok = &{1'b0, busin_addr[31:4], busin_addr[1:0], busin_wdata};

  assign accept = busin_valid & ~ready_q;
  assign is_wr  = accept & (|busin_wstrb);
  assign is_rd  = accept & ~(|busin_wstrb);
  assign sel    = busin_addr[3:2];

  // Active-high segment pattern {dp,g..a} for a stored byte.
  function automatic logic [7:0] seg_of(input logic [7:0] b, input logic hex);
    logic [6:0] s;
    case (b[3:0])
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return hex ? {b[7], s} : b;
  endfunction

  // Register read mux; bytes and mask bits beyond NUM_DIGITS stay zero.
  always_comb begin
    data_all = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) data_all[8*i +: 8] = pat_q[i];
    ctrl_rd = '0;
    ctrl_rd[0] = hex_q;
    ctrl_rd[8 +: NUM_DIGITS] = en_q;
    ctrl_rd[19:16] = bright_q;
`ifdef SSEG_BLINK_EN
    ctrl_rd[24 +: NUM_DIGITS] = blink_mask_q;
`endif
    status_rd = {23'd0, frame_q, 5'd0, idx_q};
    case (sel)
      2'd0:    rd_val = data_all[31:0];
      2'd1:    rd_val = data_all[63:32];
      2'd2:    rd_val = ctrl_rd;
      default: rd_val = status_rd;
    endcase
  end

  // Byte-strobed register writes, applied on the accept edge.
  always_comb begin
    pat_d    = pat_q;
    hex_d    = hex_q;
    en_d     = en_q;
    bright_d = bright_q;
`ifdef SSEG_BLINK_EN
    blink_mask_d = blink_mask_q;
`endif
    if (is_wr) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (sel == 2'(i / 4) && busin_wstrb[i % 4]) pat_d[i] = busin_wdata[8*(i % 4) +: 8];
      end
      if (sel == 2'd2) begin
        if (busin_wstrb[0]) hex_d    = busin_wdata[0];
        if (busin_wstrb[1]) en_d     = busin_wdata[8 +: NUM_DIGITS];
        if (busin_wstrb[2]) bright_d = busin_wdata[19:16];
`ifdef SSEG_BLINK_EN
        if (busin_wstrb[3]) blink_mask_d = busin_wdata[24 +: NUM_DIGITS];
`endif
      end
    end
  end

  // Scan timebase: cycles -> phase -> digit index -> frame.
  always_comb begin
    cnt_last   = (cnt_q == CNT_W'(PHASE_DIV - 1));
    slot_end   = cnt_last && (phase_q == 4'd15);
    frame_wrap = slot_end && (idx_q == 3'(NUM_DIGITS - 1));
    cnt_d      = cnt_last ? '0 : cnt_q + 1'b1;
    phase_d    = cnt_last ? phase_q + 4'd1 : phase_q;
    idx_d      = slot_end ? (frame_wrap ? 3'd0 : idx_q + 3'd1) : idx_q;
    frame_d    = frame_q ^ frame_wrap;
`ifdef SSEG_BLINK_EN
    blink_cnt_d = frame_wrap ? blink_cnt_q + 6'd1 : blink_cnt_q;
    blink_d     = blink_q ^ (frame_wrap && (blink_cnt_q == 6'd63));
`endif
  end

  // Display drive; the last cycle of a slot is blanked so digit changes never overlap.
  always_comb begin
`ifdef SSEG_BLINK_EN
    vis = en_q & ~(blink_mask_q & {NUM_DIGITS{blink_q}});
`else
    vis = en_q;
`endif
    led_d  = '1;
    sseg_d = 8'hFF;
    if (!((NUM_DIGITS > 1) && slot_end)) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (idx_q == 3'(i) && vis[i] && (phase_q <= bright_q)) begin
          led_d[i] = 1'b0;
          sseg_d   = ~seg_of(pat_q[i], hex_q);
        end
      end
    end
    ready_d = accept;
    rdata_d = is_rd ? rd_val : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      sseg_q   <= 8'hFF;
      led_q    <= '1;
      pat_q    <= '0;
      hex_q    <= 1'b0;
      en_q     <= '1;
      bright_q <= 4'd15;
      cnt_q    <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
`ifdef SSEG_BLINK_EN
      blink_mask_q <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
`endif
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      sseg_q   <= sseg_d;
      led_q    <= led_d;
      pat_q    <= pat_d;
      hex_q    <= hex_d;
      en_q     <= en_d;
      bright_q <= bright_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
`ifdef SSEG_BLINK_EN
      blink_mask_q <= blink_mask_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_q      <= blink_d;
`endif
    end
  end

  assign busout_ready = ready_q;
  assign busout_rdata = rdata_q;
  assign busout_sseg  = sseg_q;
  assign busout_led   = led_q;

endmodule
